uart_boot_loader: RTL and testbench



---
 rtl/uart_boot_pkg.sv | 22 ++
 rtl/uart_boot_loader_if.sv | 28 ++
 rtl/uart_boot_timeout.sv | 37 +++
 rtl/uart_boot_loader.sv | 190 +++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_boot_pkg.sv
// uart_boot_pkg: shared types and protocol constants for the UART boot loader.
// Contents: FSM state enum, frame sync/command bytes and response codes.
package uart_boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddrH,
        StAddrL,
        StCount,
        StData,
        StCsum,
        StResp
    } boot_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;

endpackage

// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: groups the RX byte stream, RAM write port, TX FIFO port
// and status outputs of the boot loader.
//   master : the boot loader (consumes rx/tx_full, drives RAM/TX/status)
//   slave  : the environment (byte source, RAM, TX FIFO, CORE)
interface uart_boot_loader_if #(
    parameter int unsigned ADDR_W = 13
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_data;
    logic              ram_we;
    logic [7:0]        tx_data;
    logic              tx_wr;
    logic              tx_full;
    logic              core_run;
    logic              busy;

    modport master (
        input  rx_data, rx_valid, tx_full,
        output ram_addr, ram_data, ram_we, tx_data, tx_wr, core_run, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_full,
        input  ram_addr, ram_data, ram_we, tx_data, tx_wr, core_run, busy
    );
endinterface

// File: rtl/uart_boot_timeout.sv
// uart_boot_timeout: inter-byte idle counter.
//   clk, rst_n  : clock, async active-low reset
//   clear_i     : restart the count at zero (takes priority over enable_i)
//   enable_i    : count this cycle
//   expired_o   : high in the TIMEOUT_CYCLES-th consecutive enabled, uncleared cycle
module uart_boot_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 180000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && !clear_i && (count_q == CntW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses boot frames from the RX byte stream, writes 32-bit
// words to program RAM, answers each complete frame with ACK/NAK into the TX
// FIFO and raises a sticky core_run on a valid RUN frame.
//   clk, rst_n : clock, async active-low reset
//   bus        : rx_data/rx_valid in, ram_addr/ram_data/ram_we out,
//                tx_data/tx_wr out with tx_full in, core_run/busy out
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 180000000,
    parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 1000,
    parameter int unsigned ADDR_W         = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_boot_loader_if.master bus
);
    boot_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        resp_q, resp_d;
    logic              is_run_q, is_run_d;
    logic              run_ok_q, run_ok_d;
    logic              core_run_q, core_run_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_data_q, ram_data_d;
    logic              tx_wr;
    logic              tmo_enable, tmo_clear, tmo_expired;

    assign tmo_enable = (state_q != StIdle) && (state_q != StResp);
    assign tmo_clear  = bus.rx_valid || !tmo_enable;

    uart_boot_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (tmo_clear),
        .enable_i (tmo_enable),
        .expired_o(tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        csum_d     = csum_q;
        resp_d     = resp_q;
        is_run_d   = is_run_q;
        run_ok_d   = run_ok_q;
        core_run_d = core_run_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        tx_wr      = 1'b0;

        // Every byte between SYNC and CSUM feeds the running checksum.
        if (bus.rx_valid && tmo_enable && (state_q != StCsum)) begin
            csum_d = csum_q ^ bus.rx_data;
        end

        case (state_q)
            StIdle: begin
                if (bus.rx_valid && !core_run_q && (bus.rx_data == SYNC_BYTE)) begin
                    csum_d  = '0;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == CMD_WRITE) begin
                        is_run_d = 1'b0;
                        state_d  = StAddrH;
                    end else if (bus.rx_data == CMD_RUN) begin
                        is_run_d = 1'b1;
                        state_d  = StCsum;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StAddrH: begin
                if (bus.rx_valid) begin
                    // Truncation drops the unused high bits of ADDR_H.
                    addr_d  = ADDR_W'({bus.rx_data, 8'h00});
                    state_d = StAddrL;
                end
            end
            StAddrL: begin
                if (bus.rx_valid) begin
                    addr_d[7:0] = bus.rx_data;
                    state_d     = StCount;
                end
            end
            StCount: begin
                if (bus.rx_valid) begin
                    cnt_d      = bus.rx_data;
                    byte_idx_d = '0;
                    state_d    = StData;
                end
            end
            StData: begin
                if (bus.rx_valid) begin
                    // Shift in from the top so byte 0 ends in bits 7:0.
                    word_d     = {bus.rx_data, word_q[31:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        ram_we_d   = 1'b1;
                        ram_addr_d = addr_q;
                        ram_data_d = word_d;
                        addr_d     = addr_q + ADDR_W'(1);
                        if (cnt_q == 8'd0) begin
                            state_d = StCsum;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
            end
            StCsum: begin
                if (bus.rx_valid) begin
                    resp_d   = (bus.rx_data == csum_q) ? RESP_ACK : RESP_NAK;
                    run_ok_d = is_run_q && (bus.rx_data == csum_q);
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (!bus.tx_full) begin
                    tx_wr = 1'b1;
                    if (run_ok_q) begin
                        core_run_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A byte arriving in the expiry cycle wins over the timeout.
        if (tmo_expired && !bus.rx_valid) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            cnt_q      <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            resp_q     <= '0;
            is_run_q   <= 1'b0;
            run_ok_q   <= 1'b0;
            core_run_q <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            resp_q     <= resp_d;
            is_run_q   <= is_run_d;
            run_ok_q   <= run_ok_d;
            core_run_q <= core_run_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_data = ram_data_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.tx_data  = resp_q;
    assign bus.tx_wr    = tx_wr;
    assign bus.core_run = core_run_q;
    assign bus.busy     = (state_q != StIdle);
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed frames; a frame-level model queues the expected
// RAM writes and responses, and one negedge process checks every DUT strobe.
module tb_uart_boot_loader;
    localparam int unsigned TC = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_boot_loader_if #(.ADDR_W(13)) bus ();

    uart_boot_loader #(
        .CLK_FREQ      (20000),
        .TIMEOUT_CYCLES(TC),
        .ADDR_W        (13)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [12:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  fq[$];
    bit          run_armed = 1'b0;
    bit          run_fired = 1'b0;
    bit          model_run = 1'b0;
    logic [12:0] last_we_addr = '0;
    logic [7:0]  last_tx = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Compare process: every RAM write / TX write must match the model queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (run_fired) model_run = 1'b1;
            check("core_run", {31'd0, bus.core_run}, {31'd0, model_run});
            if (bus.ram_we === 1'b1) begin
                last_we_addr = bus.ram_addr;
                if (exp_addr.size() == 0) begin
                    check("ram_we_unexpected", {31'd0, bus.ram_we}, 32'd0);
                end else begin
                    check("ram_addr", {19'd0, bus.ram_addr}, {19'd0, exp_addr.pop_front()});
                    check("ram_data", bus.ram_data, exp_data.pop_front());
                end
            end
            if (bus.tx_wr === 1'b1) begin
                last_tx = bus.tx_data;
                check("tx_wr_while_full", {31'd0, bus.tx_full}, 32'd0);
                check("we_and_tx_same_cycle", {31'd0, bus.ram_we}, 32'd0);
                if (exp_tx.size() == 0) begin
                    check("tx_wr_unexpected", {31'd0, bus.tx_wr}, 32'd0);
                end else begin
                    check("tx_data", {24'd0, bus.tx_data}, {24'd0, exp_tx.pop_front()});
                end
                if (run_armed && bus.tx_data == 8'h06) run_fired = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_fq();
        while (fq.size() > 0) send_byte(fq.pop_front());
    endtask

    // Frame-level model: builds a WRITE frame and, if effects is set, queues
    // the words it must write (address wraps mod 8192) and its response.
    task automatic build_write(input logic [7:0] ah, input logic [7:0] al, input logic [7:0] cnt,
                               input logic [31:0] seed, input bit bad, input bit effects);
        logic [7:0]  cs;
        logic [31:0] w;
        int          base;
        cs   = 8'h01 ^ ah ^ al ^ cnt;
        base = int'({ah, al} & 16'h1FFF);
        fq.push_back(8'hA5);
        fq.push_back(8'h01);
        fq.push_back(ah);
        fq.push_back(al);
        fq.push_back(cnt);
        for (int i = 0; i <= int'(cnt); i++) begin
            w = seed + 32'(i) * 32'h01010101;
            for (int b = 0; b < 4; b++) begin
                fq.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
            if (effects) begin
                exp_addr.push_back(13'((base + i) % 8192));
                exp_data.push_back(w);
            end
        end
        fq.push_back(bad ? (cs ^ 8'h01) : cs);
        if (effects) exp_tx.push_back(bad ? 8'h15 : 8'h06);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && (exp_addr.size() != 0 || exp_tx.size() != 0); i++) tick();
        repeat (3) tick();
        check({name, "_writes_left"}, 32'(exp_addr.size()), 32'd0);
        check({name, "_resp_left"}, 32'(exp_tx.size()), 32'd0);
        check({name, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ram_addr"}, {19'd0, bus.ram_addr}, 32'd0);
        check({name, "_ram_data"}, bus.ram_data, 32'd0);
        check({name, "_ram_we"}, {31'd0, bus.ram_we}, 32'd0);
        check({name, "_tx_data"}, {24'd0, bus.tx_data}, 32'd0);
        check({name, "_tx_wr"}, {31'd0, bus.tx_wr}, 32'd0);
        check({name, "_core_run"}, {31'd0, bus.core_run}, 32'd0);
        check({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1[$];
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.tx_full  = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Non-sync byte in IDLE and unknown command: ignored silently.
        send_byte(8'h11);
        check("idle_ignore_busy", {31'd0, bus.busy}, 32'd0);
        send_byte(8'hA5);
        send_byte(8'h07);
        check("bad_cmd_busy", {31'd0, bus.busy}, 32'd0);

        // Single word, hand-computed: csum = 0x55.
        t1 = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h44, 8'h33, 8'h22};
        exp_addr.push_back(13'h0010);
        exp_data.push_back(32'h11223344);
        exp_tx.push_back(8'h06);
        foreach (t1[i]) send_byte(t1[i]);
        send_byte(8'h11);
        check("w1_ram_we_latency", {31'd0, bus.ram_we}, 32'd1);
        check("w1_ram_addr", {19'd0, bus.ram_addr}, 32'h0010);
        check("w1_ram_data", bus.ram_data, 32'h11223344);
        send_byte(8'h55);
        check("w1_tx_wr_latency", {31'd0, bus.tx_wr}, 32'd1);
        check("w1_tx_data", {24'd0, bus.tx_data}, 32'h06);
        check("w1_busy_resp", {31'd0, bus.busy}, 32'd1);
        tick();
        check("w1_busy_drop", {31'd0, bus.busy}, 32'd0);
        drain("w1");

        // Address wrap: ADDR_H=0xFF (bits 7:5 ignored), ADDR_L=0xFF, two words.
        build_write(8'hFF, 8'hFF, 8'h01, 32'hCAFE0000, 1'b0, 1'b1);
        send_fq();
        drain("wrap");
        check("wrap_last_addr", {19'd0, last_we_addr}, 32'h0000);

        // Bad checksum: word still written, NAK returned.
        build_write(8'h00, 8'h20, 8'h00, 32'hDEADBEEF, 1'b1, 1'b1);
        send_fq();
        drain("badcs");
        check("badcs_nak", {24'd0, last_tx}, 32'h15);
        check("badcs_core_run", {31'd0, bus.core_run}, 32'd0);

        // Multi-word frame with varied data.
        build_write(8'h03, 8'hF0, 8'h04, 32'h00FF7F80, 1'b0, 1'b1);
        send_fq();
        drain("multi");

        // Timeout after A5 01 00: still busy after TC-1 idle cycles, idle after TC.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (TC - 1) tick();
        check("tmo_busy_before", {31'd0, bus.busy}, 32'd1);
        tick();
        check("tmo_busy_after", {31'd0, bus.busy}, 32'd0);
        build_write(8'h00, 8'h40, 8'h00, 32'h01020304, 1'b0, 1'b1);
        send_fq();
        drain("after_tmo");

        // Reset after two data bytes: outputs drop asynchronously, no write.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h30);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        build_write(8'h00, 8'h30, 8'h00, 32'h55AA55AA, 1'b0, 1'b1);
        send_fq();
        drain("after_reset");

        // RUN with backpressure: tx_wr waits for tx_full to fall.
        bus.tx_full = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h02);
        for (int i = 0; i < 5; i++) begin
            check("run_hold_tx_wr", {31'd0, bus.tx_wr}, 32'd0);
            check("run_hold_busy", {31'd0, bus.busy}, 32'd1);
            tick();
        end
        exp_tx.push_back(8'h06);
        run_armed   = 1'b1;
        bus.tx_full = 1'b0;
        #1;
        check("run_tx_wr", {31'd0, bus.tx_wr}, 32'd1);
        check("run_tx_data", {24'd0, bus.tx_data}, 32'h06);
        tick();
        check("run_core_run", {31'd0, bus.core_run}, 32'd1);
        drain("run");

        // After core_run, a full WRITE frame is ignored.
        build_write(8'h00, 8'h50, 8'h00, 32'h77777777, 1'b0, 1'b0);
        send_fq();
        drain("post_run");
        check("post_run_core_run", {31'd0, bus.core_run}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
